mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single synchronous memory port between two requesters: the CPU load/store/fetch path (sequenced by the control FSM) and a DMA/IO loader port.
- Each requester uses a req/ack handshake; the arbiter serialises transactions and drives the memory port.
- CPU has fixed priority, bounded by a starvation guard so DMA always progresses.
- Sits between the control/datapath and the memory model; the control FSM stalls in fetch/load/store states until cpu_ack.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 16, memory word width.
- MAX_CPU_STREAK, 4, maximum consecutive CPU grants while dma_req is pending; must be 1..15.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU transaction request; fields must be stable while high.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same as the cpu_* ports, for the DMA requester.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_en with mem_we = 0.
- busy  out  1  high in ISSUE and RESP.
- owner  out  1  0 = CPU, 1 = DMA; the last granted requester.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; streak = 0; owner = 0.
  - mem_en, mem_we, cpu_ack, dma_ack, busy = 0.
  - Latched address/data and both rdata holding registers = 0.
  - An in-flight transaction is dropped, with no ack.
  - Reset release is taken synchronously on a clk edge.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - A request is present: select the winner, latch its we/addr/wdata into registers, set owner, go to ISSUE.
  - Winner rule: DMA wins if dma_req and (not cpu_req, or streak == MAX_CPU_STREAK); otherwise the CPU wins when cpu_req.
- ISSUE:
  - mem_en = 1; mem_we/mem_addr/mem_wdata come from the latched registers.
  - Always go to RESP.
  - mem_addr/mem_wdata hold their latched values in all states. mem_en is 0 outside ISSUE.
- RESP:
  - Assert the owner's ack for exactly this cycle.
  - Owner rdata = mem_rdata combinationally for a read. For a write, rdata shows the holding register.
  - At the end of RESP, the holding register captures mem_rdata (reads only).
  - Always go to IDLE.
- rdata outside RESP: the holding register value. The non-owner rdata never changes.
- Latency: req seen in IDLE at cycle N → mem_en at N+1 → ack at N+2. Peak throughput is one transaction per 3 cycles.
- Back-to-back: a req still high in IDLE after an ack is a new transaction. Requesters wanting a single access must drop req by the cycle after ack.
- Streak counter (updated on the IDLE→ISSUE transition):
  - CPU granted while dma_req is high: streak + 1, saturating at MAX_CPU_STREAK.
  - DMA granted, or CPU granted with dma_req low: streak = 0.
- Simultaneous requests with streak below the limit: CPU wins and DMA waits.
- Requests that rise during ISSUE/RESP are ignored until IDLE. No request is lost, because requesters hold req until ack.
- Request fields changing while req is high: undefined. The bench asserts against it.
- Width rules: no arithmetic on data. Streak width = 4 bits.

Decomposition:
- Shared parameters include file:
  - ARB_IDLE/ARB_ISSUE/ARB_RESP state encodings (2 bits).
  - OWNER_CPU = 0, OWNER_DMA = 1.
  - ADDR_WIDTH/DATA_WIDTH defaults, alongside the existing NIB_WIDTH.
- One sub-module is natural: arb_pick, the combinational winner select plus the streak counter register, so the fairness logic can be verified in isolation. Everything else stays in mem_arbiter.

Test Plan:
- CPU read only: cpu_req, addr 0x0010, mem holds 0xBEEF → mem_en at N+1 with addr 0x0010 and we = 0; cpu_ack at N+2 with cpu_rdata = 0xBEEF; dma_ack stays 0.
- DMA write: dma_req, we = 1, addr 0x0200, wdata 0x1234 → mem_en, mem_we = 1, mem_wdata = 0x1234 at N+1; dma_ack at N+2; memory location reads back 0x1234.
- Simultaneous first requests: cpu_req and dma_req both rise at N with streak = 0 → CPU acked at N+2; DMA granted in the next IDLE (N+3) and acked at N+5.
- Starvation guard: cpu_req held high continuously and dma_req high, MAX_CPU_STREAK = 4 → exactly 4 cpu_acks, then a dma_ack, then the CPU resumes; streak returns to 0.
- Reset mid-transaction: rst_n low during ISSUE → mem_en and acks drop immediately; state = IDLE; no ack for the dropped transaction; a request after release completes normally in 3 cycles.
- rdata hold: CPU read returns 0xBEEF, then a DMA write → cpu_rdata stays 0xBEEF throughout, and dma_rdata is unchanged by the write.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: state encodings, owner codes
// and default widths.
package mem_arbiter_pkg;

  localparam int NIB_WIDTH        = 4;
  localparam int ADDR_WIDTH_DEF   = 16;
  localparam int DATA_WIDTH_DEF   = 16;
  localparam int STREAK_WIDTH     = NIB_WIDTH;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner select for the shared memory port: CPU has fixed priority, but after
// MAX_CPU_STREAK consecutive CPU grants with DMA waiting, DMA is forced through.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cpu_req,
  input  logic                    i_dma_req,
  input  logic                    i_grant_en,
  output logic                    o_pick_dma,
  output logic [STREAK_WIDTH-1:0] o_streak
);

  localparam logic [STREAK_WIDTH-1:0] MAX_S = STREAK_WIDTH'(MAX_CPU_STREAK);

  logic [STREAK_WIDTH-1:0] r_streak;
  logic                    w_pick_dma;
  logic                    w_grant;

  assign w_pick_dma = i_dma_req && (!i_cpu_req || (r_streak == MAX_S));
  assign w_grant    = i_grant_en && (i_cpu_req || i_dma_req);

  // Streak only counts CPU grants that actually made DMA wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_grant) begin
      if (!w_pick_dma && i_dma_req) begin
        if (r_streak != MAX_S) r_streak <= r_streak + 1'b1;
      end else begin
        r_streak <= '0;
      end
    end
  end

  assign o_pick_dma = w_pick_dma;
  assign o_streak   = r_streak;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA req/ack transactions onto one synchronous memory port
// using an IDLE -> ISSUE -> RESP sequence (one transaction per three cycles).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cpu_req,
  input  logic                    i_cpu_we,
  input  logic [ADDR_WIDTH-1:0]   i_cpu_addr,
  input  logic [DATA_WIDTH-1:0]   i_cpu_wdata,
  output logic                    o_cpu_ack,
  output logic [DATA_WIDTH-1:0]   o_cpu_rdata,
  input  logic                    i_dma_req,
  input  logic                    i_dma_we,
  input  logic [ADDR_WIDTH-1:0]   i_dma_addr,
  input  logic [DATA_WIDTH-1:0]   i_dma_wdata,
  output logic                    o_dma_ack,
  output logic [DATA_WIDTH-1:0]   o_dma_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_busy,
  output logic                    o_owner,
  output logic [1:0]              o_dbg_state,
  output logic [STREAK_WIDTH-1:0] o_dbg_streak
);

  // Handshake: a requester raises req with stable fields and holds it until
  // its one-cycle ack; req still high in IDLE after an ack is a new request.
  arb_state_t            r_state;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_mem_en;
  logic                  r_cpu_ack;
  logic                  r_dma_ack;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_cpu_hold;
  logic [DATA_WIDTH-1:0] r_dma_hold;

  logic w_pick_dma;
  logic w_any_req;
  logic w_in_idle;
  logic w_read_resp;

  assign w_any_req   = i_cpu_req || i_dma_req;
  assign w_in_idle   = (r_state == ARB_IDLE);
  assign w_read_resp = (r_state == ARB_RESP) && !r_we;

  arb_pick #(
    .MAX_CPU_STREAK (MAX_CPU_STREAK)
  ) u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cpu_req  (i_cpu_req),
    .i_dma_req  (i_dma_req),
    .i_grant_en (w_in_idle),
    .o_pick_dma (w_pick_dma),
    .o_streak   (o_dbg_streak)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWNER_CPU;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_en   <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_dma_ack  <= 1'b0;
      r_busy     <= 1'b0;
      r_cpu_hold <= '0;
      r_dma_hold <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_state  <= ARB_ISSUE;
            r_mem_en <= 1'b1;
            r_busy   <= 1'b1;
            r_owner  <= w_pick_dma ? OWNER_DMA : OWNER_CPU;
            r_we     <= w_pick_dma ? i_dma_we    : i_cpu_we;
            r_addr   <= w_pick_dma ? i_dma_addr  : i_cpu_addr;
            r_wdata  <= w_pick_dma ? i_dma_wdata : i_cpu_wdata;
          end
        end
        ARB_ISSUE: begin
          r_state   <= ARB_RESP;
          r_mem_en  <= 1'b0;
          r_cpu_ack <= (r_owner == OWNER_CPU);
          r_dma_ack <= (r_owner == OWNER_DMA);
        end
        ARB_RESP: begin
          r_state   <= ARB_IDLE;
          r_cpu_ack <= 1'b0;
          r_dma_ack <= 1'b0;
          r_busy    <= 1'b0;
          if (!r_we) begin
            if (r_owner == OWNER_DMA) r_dma_hold <= i_mem_rdata;
            else                      r_cpu_hold <= i_mem_rdata;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Read data is forwarded straight from memory in RESP so ack and data align.
  assign o_cpu_rdata = (w_read_resp && r_owner == OWNER_CPU) ? i_mem_rdata : r_cpu_hold;
  assign o_dma_rdata = (w_read_resp && r_owner == OWNER_DMA) ? i_mem_rdata : r_dma_hold;

  assign o_cpu_ack   = r_cpu_ack;
  assign o_dma_ack   = r_dma_ack;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_we && r_mem_en;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = r_busy;
  assign o_owner     = r_owner;
  assign o_dbg_state = r_state;

endmodule
